// File: rtl/writeback_buffer_v.sv
// writeback_buffer_v: per-lane writeback FIFO between the vector ALU and the
// lane register file write port. It queues ALU results, drains them when the
// write port is granted, and exposes the newest accepted result as a bypass.
module writeback_buffer_v #(
  parameter int WIDTH_DATA  = 32,
  parameter int WIDTH_INDEX = 8,
  parameter int DEPTH       = 4,
  parameter int LANE_ID     = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     I_Flush,
  input  logic                     I_Valid,
  input  logic [WIDTH_INDEX-1:0]   I_DstIdx,
  input  logic [WIDTH_DATA-1:0]    I_Data,
  output logic                     O_Stall,
  input  logic                     I_RF_Ready,
  output logic                     O_RF_We,
  output logic [WIDTH_INDEX-1:0]   O_RF_Idx,
  output logic [WIDTH_DATA-1:0]    O_RF_Data,
  output logic                     O_WB_Valid,
  output logic [WIDTH_INDEX-1:0]   O_WB_DstIdx,
  output logic [WIDTH_DATA-1:0]    O_WB_Data,
  output logic [$clog2(DEPTH):0]   O_Count,
  output logic                     O_Overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Pointers wrap by natural overflow, so the depth must be a power of two.
  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || LANE_ID < 0) begin : g_bad_param
      $error("writeback_buffer_v: DEPTH must be a power of two >= 2 and LANE_ID >= 0");
    end
  endgenerate

  logic [WIDTH_INDEX-1:0] idx_mem  [DEPTH];
  logic [WIDTH_DATA-1:0]  data_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  logic                   wb_valid_reg;
  logic [WIDTH_INDEX-1:0] wb_idx_reg;
  logic [WIDTH_DATA-1:0]  wb_data_reg;
  logic                   overflow_reg;

  logic full;
  logic empty;
  logic enq;
  logic deq;

  // Full/empty come only from registered count; flush suppresses both
  // transfers, and a full buffer refuses input even while it drains.
  assign full  = (count_reg == CNT_W'(DEPTH));
  assign empty = (count_reg == '0);
  assign enq   = I_Valid & ~full & ~I_Flush;
  assign deq   = ~empty & I_RF_Ready & ~I_Flush;

  assign O_Stall    = full;
  assign O_Count    = count_reg;
  assign O_RF_We    = deq;
  assign O_RF_Idx   = empty ? '1 : idx_mem[rd_ptr_reg];
  assign O_RF_Data  = empty ? '0 : data_mem[rd_ptr_reg];
  assign O_WB_Valid  = wb_valid_reg;
  assign O_WB_DstIdx = wb_idx_reg;
  assign O_WB_Data   = wb_data_reg;
  assign O_Overflow  = overflow_reg;

  // Storage array: written on enqueue; contents are don't-care while empty.
  always_ff @(posedge clock) begin
    if (enq) begin
      idx_mem[wr_ptr_reg]  <= I_DstIdx;
      data_mem[wr_ptr_reg] <= I_Data;
    end
  end

  // Pointer and occupancy bookkeeping; flush empties the buffer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (I_Flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (enq) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (deq) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Bypass tracks the newest accepted result; it is dropped once that entry
  // leaves the buffer with nothing newer arriving. Invalid index is all-ones
  // so it can never match a real source operand.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wb_valid_reg <= 1'b0;
      wb_idx_reg   <= '1;
      wb_data_reg  <= '0;
    end else if (I_Flush) begin
      wb_valid_reg <= 1'b0;
      wb_idx_reg   <= '1;
      wb_data_reg  <= '0;
    end else if (enq) begin
      wb_valid_reg <= 1'b1;
      wb_idx_reg   <= I_DstIdx;
      wb_data_reg  <= I_Data;
    end else if (deq && count_reg == CNT_W'(1)) begin
      wb_valid_reg <= 1'b0;
      wb_idx_reg   <= '1;
      wb_data_reg  <= '0;
    end
  end

  // Sticky overflow: a result was offered while full. Survives flush.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow_reg <= 1'b0;
    end else if (I_Valid && full) begin
      overflow_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_writeback_buffer_v.sv
// Directed testbench for writeback_buffer_v (DEPTH=4, 8-bit index, 32-bit data).
module tb_writeback_buffer_v;

  logic        clock;
  logic        reset;
  logic        I_Flush;
  logic        I_Valid;
  logic [7:0]  I_DstIdx;
  logic [31:0] I_Data;
  logic        O_Stall;
  logic        I_RF_Ready;
  logic        O_RF_We;
  logic [7:0]  O_RF_Idx;
  logic [31:0] O_RF_Data;
  logic        O_WB_Valid;
  logic [7:0]  O_WB_DstIdx;
  logic [31:0] O_WB_Data;
  logic [2:0]  O_Count;
  logic        O_Overflow;

  int n_cmp = 0;
  int n_err = 0;

  writeback_buffer_v #(
    .WIDTH_DATA(32), .WIDTH_INDEX(8), .DEPTH(4), .LANE_ID(0)
  ) dut (
    .clock(clock), .reset(reset), .I_Flush(I_Flush), .I_Valid(I_Valid),
    .I_DstIdx(I_DstIdx), .I_Data(I_Data), .O_Stall(O_Stall),
    .I_RF_Ready(I_RF_Ready), .O_RF_We(O_RF_We), .O_RF_Idx(O_RF_Idx),
    .O_RF_Data(O_RF_Data), .O_WB_Valid(O_WB_Valid), .O_WB_DstIdx(O_WB_DstIdx),
    .O_WB_Data(O_WB_Data), .O_Count(O_Count), .O_Overflow(O_Overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // The reserved index must never be offered as a destination.
  always @(posedge clock) begin
    if (!reset && I_Valid === 1'b1 && I_DstIdx === 8'hFF)
      $error("illegal destination index 0xFF driven");
  end

  task automatic step;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset;
    @(negedge clock);
    reset = 1'b1; I_Flush = 0; I_Valid = 0; I_RF_Ready = 0; I_DstIdx = 0; I_Data = 0;
    #2;
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic enqueue(input logic [7:0] idx, input logic [31:0] data);
    I_Valid = 1'b1; I_DstIdx = idx; I_Data = data;
    step();
    I_Valid = 1'b0;
    $display("txn enqueue idx=%0d data=%0h count=%0d", idx, data, O_Count);
  endtask

  task automatic test_reset;
    reset = 1'b1; I_Flush = 0; I_Valid = 0; I_RF_Ready = 0; I_DstIdx = 0; I_Data = 0;
    step(); #1;
    n_cmp++; if (O_Count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", O_Count); end
    n_cmp++; if (O_Stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %0b want 0", O_Stall); end
    n_cmp++; if (O_RF_Idx !== 8'hFF || O_RF_Data !== 32'h0 || O_RF_We !== 1'b0) begin n_err++; $display("FAIL reset_rf: got we=%0b idx=%0h data=%0h want 0/ff/0", O_RF_We, O_RF_Idx, O_RF_Data); end
    n_cmp++; if (O_WB_Valid !== 1'b0 || O_WB_DstIdx !== 8'hFF || O_WB_Data !== 32'h0) begin n_err++; $display("FAIL reset_wb: got v=%0b idx=%0h data=%0h want 0/ff/0", O_WB_Valid, O_WB_DstIdx, O_WB_Data); end
    n_cmp++; if (O_Overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %0b want 0", O_Overflow); end
    @(negedge clock);
    reset = 1'b0;
    $display("txn reset released");
  endtask

  task automatic test_single_write;
    I_Valid = 1; I_DstIdx = 8'd5; I_Data = 32'h11; I_RF_Ready = 1;
    #1;
    n_cmp++; if (O_RF_We !== 1'b0) begin n_err++; $display("FAIL single_no_passthru: got we=%0b want 0", O_RF_We); end
    step();
    I_Valid = 0; #1;
    n_cmp++; if (O_RF_We !== 1'b1 || O_RF_Idx !== 8'd5 || O_RF_Data !== 32'h11) begin n_err++; $display("FAIL single_rf: got we=%0b idx=%0d data=%0h want 1/5/11", O_RF_We, O_RF_Idx, O_RF_Data); end
    n_cmp++; if (O_WB_Valid !== 1'b1 || O_WB_DstIdx !== 8'd5 || O_WB_Data !== 32'h11) begin n_err++; $display("FAIL single_wb: got v=%0b idx=%0d data=%0h want 1/5/11", O_WB_Valid, O_WB_DstIdx, O_WB_Data); end
    n_cmp++; if (O_Count !== 3'd1) begin n_err++; $display("FAIL single_count1: got %0d want 1", O_Count); end
    step(); #1;
    n_cmp++; if (O_WB_Valid !== 1'b0 || O_WB_DstIdx !== 8'hFF || O_WB_Data !== 32'h0) begin n_err++; $display("FAIL single_wb_clear: got v=%0b idx=%0h data=%0h want 0/ff/0", O_WB_Valid, O_WB_DstIdx, O_WB_Data); end
    n_cmp++; if (O_Count !== 3'd0 || O_RF_We !== 1'b0) begin n_err++; $display("FAIL single_empty: got count=%0d we=%0b want 0/0", O_Count, O_RF_We); end
    $display("txn single write idx=5 done");
  endtask

  task automatic test_fill;
    I_RF_Ready = 0;
    for (int i = 1; i <= 4; i++) enqueue(8'(i), 32'hA0 + 32'(i));
    #1;
    n_cmp++; if (O_Count !== 3'd4 || O_Stall !== 1'b1) begin n_err++; $display("FAIL fill_full: got count=%0d stall=%0b want 4/1", O_Count, O_Stall); end
    n_cmp++; if (O_Overflow !== 1'b0) begin n_err++; $display("FAIL fill_ovf_pre: got %0b want 0", O_Overflow); end
    enqueue(8'd9, 32'h99);
    #1;
    n_cmp++; if (O_Overflow !== 1'b1 || O_Count !== 3'd4) begin n_err++; $display("FAIL fill_ovf: got ovf=%0b count=%0d want 1/4", O_Overflow, O_Count); end
    n_cmp++; if (O_WB_DstIdx !== 8'd4) begin n_err++; $display("FAIL fill_wb_keep: got %0d want 4", O_WB_DstIdx); end
    I_RF_Ready = 1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      n_cmp++; if (O_RF_We !== 1'b1 || O_RF_Idx !== 8'(i) || O_RF_Data !== 32'hA0 + 32'(i)) begin n_err++; $display("FAIL fill_drain%0d: got we=%0b idx=%0d data=%0h want 1/%0d/%0h", i, O_RF_We, O_RF_Idx, O_RF_Data, i, 32'hA0 + 32'(i)); end
      $display("txn drain idx=%0d", O_RF_Idx);
      step();
    end
    #1;
    n_cmp++; if (O_Count !== 3'd0 || O_Stall !== 1'b0 || O_WB_Valid !== 1'b0) begin n_err++; $display("FAIL fill_after: got count=%0d stall=%0b wbv=%0b want 0/0/0", O_Count, O_Stall, O_WB_Valid); end
  endtask

  task automatic test_back_to_back;
    do_reset();
    enqueue(8'd10, 32'h10A);
    enqueue(8'd11, 32'h10B);
    I_Valid = 1; I_RF_Ready = 1;
    for (int k = 0; k < 6; k++) begin
      I_DstIdx = 8'(12 + k); I_Data = 32'h100 + 32'(12 + k);
      #1;
      n_cmp++; if (O_RF_We !== 1'b1 || O_RF_Idx !== 8'(10 + k) || O_RF_Data !== 32'h100 + 32'(10 + k)) begin n_err++; $display("FAIL b2b_head%0d: got we=%0b idx=%0d data=%0h want 1/%0d", k, O_RF_We, O_RF_Idx, O_RF_Data, 10 + k); end
      step(); #1;
      n_cmp++; if (O_Count !== 3'd2 || O_WB_DstIdx !== 8'(12 + k) || O_WB_Valid !== 1'b1) begin n_err++; $display("FAIL b2b_state%0d: got count=%0d wbidx=%0d wbv=%0b want 2/%0d/1", k, O_Count, O_WB_DstIdx, O_WB_Valid, 12 + k); end
      $display("txn b2b in=%0d out=%0d", 12 + k, 10 + k);
    end
    I_Valid = 0;
    for (int k = 16; k <= 17; k++) begin
      #1;
      n_cmp++; if (O_RF_Idx !== 8'(k) || O_RF_Data !== 32'h100 + 32'(k)) begin n_err++; $display("FAIL b2b_tail%0d: got idx=%0d data=%0h want %0d", k, O_RF_Idx, O_RF_Data, k); end
      step();
    end
    #1;
    n_cmp++; if (O_Count !== 3'd0 || O_WB_Valid !== 1'b0) begin n_err++; $display("FAIL b2b_empty: got count=%0d wbv=%0b want 0/0", O_Count, O_WB_Valid); end
  endtask

  task automatic test_full_dequeue;
    do_reset();
    for (int i = 20; i <= 23; i++) enqueue(8'(i), 32'h200 + 32'(i));
    I_Valid = 1; I_DstIdx = 8'd30; I_Data = 32'h300; I_RF_Ready = 1;
    #1;
    n_cmp++; if (O_Stall !== 1'b1 || O_RF_We !== 1'b1 || O_RF_Idx !== 8'd20 || O_Overflow !== 1'b0) begin n_err++; $display("FAIL fulldq_pre: got stall=%0b we=%0b idx=%0d ovf=%0b want 1/1/20/0", O_Stall, O_RF_We, O_RF_Idx, O_Overflow); end
    step();
    I_Valid = 0; #1;
    n_cmp++; if (O_Count !== 3'd3 || O_Overflow !== 1'b1) begin n_err++; $display("FAIL fulldq_post: got count=%0d ovf=%0b want 3/1", O_Count, O_Overflow); end
    n_cmp++; if (O_WB_DstIdx !== 8'd23) begin n_err++; $display("FAIL fulldq_wb: got %0d want 23", O_WB_DstIdx); end
    for (int i = 21; i <= 23; i++) begin
      #1;
      n_cmp++; if (O_RF_Idx !== 8'(i)) begin n_err++; $display("FAIL fulldq_drain: got %0d want %0d", O_RF_Idx, i); end
      step();
    end
    #1;
    n_cmp++; if (O_Count !== 3'd0) begin n_err++; $display("FAIL fulldq_empty: got %0d want 0", O_Count); end
    $display("txn full-with-dequeue done");
  endtask

  task automatic test_flush;
    I_RF_Ready = 0;
    for (int i = 40; i <= 42; i++) enqueue(8'(i), 32'h400 + 32'(i));
    #1;
    n_cmp++; if (O_Count !== 3'd3 || O_WB_Valid !== 1'b1 || O_WB_DstIdx !== 8'd42) begin n_err++; $display("FAIL flush_pre: got count=%0d wbv=%0b wbidx=%0d want 3/1/42", O_Count, O_WB_Valid, O_WB_DstIdx); end
    I_Flush = 1; I_Valid = 1; I_DstIdx = 8'd50; I_Data = 32'h500; I_RF_Ready = 1;
    #1;
    n_cmp++; if (O_RF_We !== 1'b0) begin n_err++; $display("FAIL flush_we: got %0b want 0", O_RF_We); end
    step();
    I_Flush = 0; I_Valid = 0; #1;
    n_cmp++; if (O_Count !== 3'd0 || O_RF_We !== 1'b0 || O_RF_Idx !== 8'hFF || O_RF_Data !== 32'h0) begin n_err++; $display("FAIL flush_fifo: got count=%0d we=%0b idx=%0h data=%0h want 0/0/ff/0", O_Count, O_RF_We, O_RF_Idx, O_RF_Data); end
    n_cmp++; if (O_WB_Valid !== 1'b0 || O_WB_DstIdx !== 8'hFF || O_WB_Data !== 32'h0) begin n_err++; $display("FAIL flush_wb: got v=%0b idx=%0h data=%0h want 0/ff/0", O_WB_Valid, O_WB_DstIdx, O_WB_Data); end
    n_cmp++; if (O_Overflow !== 1'b1) begin n_err++; $display("FAIL flush_ovf_kept: got %0b want 1", O_Overflow); end
    step(); #1;
    n_cmp++; if (O_Count !== 3'd0) begin n_err++; $display("FAIL flush_stays_empty: got %0d want 0", O_Count); end
    $display("txn flush done");
  endtask

  task automatic test_async_reset;
    I_RF_Ready = 0;
    for (int i = 60; i <= 62; i++) enqueue(8'(i), 32'h600 + 32'(i));
    I_RF_Ready = 1;
    step(); #1;
    n_cmp++; if (O_Count !== 3'd2 || O_RF_We !== 1'b1 || O_RF_Idx !== 8'd61) begin n_err++; $display("FAIL areset_pre: got count=%0d we=%0b idx=%0d want 2/1/61", O_Count, O_RF_We, O_RF_Idx); end
    #1; reset = 1'b1; #1;
    n_cmp++; if (O_Count !== 3'd0 || O_Stall !== 1'b0 || O_RF_We !== 1'b0 || O_RF_Idx !== 8'hFF || O_RF_Data !== 32'h0) begin n_err++; $display("FAIL areset_fifo: got count=%0d stall=%0b we=%0b idx=%0h data=%0h want 0/0/0/ff/0", O_Count, O_Stall, O_RF_We, O_RF_Idx, O_RF_Data); end
    n_cmp++; if (O_WB_Valid !== 1'b0 || O_WB_DstIdx !== 8'hFF || O_WB_Data !== 32'h0 || O_Overflow !== 1'b0) begin n_err++; $display("FAIL areset_wb: got v=%0b idx=%0h data=%0h ovf=%0b want 0/ff/0/0", O_WB_Valid, O_WB_DstIdx, O_WB_Data, O_Overflow); end
    @(negedge clock);
    reset = 1'b0; I_RF_Ready = 0; #1;
    n_cmp++; if (O_Count !== 3'd0) begin n_err++; $display("FAIL areset_after: got %0d want 0", O_Count); end
    $display("txn async reset done");
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_fill();
    test_back_to_back();
    test_full_dequeue();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/writeback_buffer_v.md
Name: writeback_buffer_v

Overview:
- Per-lane writeback stage downstream of the vector ALU and upstream of the lane register file write port.
- Buffers ALU results (destination index and data) in a small FIFO and drains them to the register file when the write port is granted.
- Presents the most recently accepted result on the WB bypass outputs (WB_DstIdx / WB_Data) consumed by the operand network.
- Backpressures the ALU when full.

Parameters:
- WIDTH_DATA, 32, data word width (matches data_t).
- WIDTH_INDEX, 8, register index width (matches index_t); the all-ones index is reserved and never a legal destination.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- LANE_ID, 0, lane number; informational only.

Ports:
- clock  in  1  clock
- reset  in  1  async active-high reset
- I_Flush  in  1  synchronous clear of buffer and bypass
- I_Valid  in  1  ALU result valid
- I_DstIdx  in  WIDTH_INDEX  ALU destination index
- I_Data  in  WIDTH_DATA  ALU result data
- O_Stall  out  1  buffer full; ALU must hold its result
- I_RF_Ready  in  1  register file write port granted this cycle
- O_RF_We  out  1  register file write enable
- O_RF_Idx  out  WIDTH_INDEX  register file write index
- O_RF_Data  out  WIDTH_DATA  register file write data
- O_WB_Valid  out  1  bypass entry valid
- O_WB_DstIdx  out  WIDTH_INDEX  bypass index (to network I_WB_DstIdx)
- O_WB_Data  out  WIDTH_DATA  bypass data (to network I_WB_Data)
- O_Count  out  $clog2(DEPTH)+1  occupied entries
- O_Overflow  out  1  sticky: I_Valid was asserted while full

Behaviour:
- Clock and reset: one clock, clock; reset is asynchronous and active-high.
- Reset values: FIFO empty, O_Count=0, O_Stall=0, O_RF_We=0, O_RF_Idx='1, O_RF_Data=0, O_WB_Valid=0, O_WB_DstIdx='1, O_WB_Data=0, O_Overflow=0. Reset mid-operation discards all entries immediately.
- FIFO: circular buffer with write pointer, read pointer and count.
  - Enqueue when I_Valid & ~full.
  - Dequeue when ~empty & I_RF_Ready.
- Head outputs: O_RF_We = ~empty & I_RF_Ready (combinational). O_RF_Idx/O_RF_Data show the head entry when non-empty, otherwise '1/0.
- Latency: a result accepted in cycle N is written to the register file no earlier than cycle N+1. There is no same-cycle pass-through.
- Full:
  - O_Stall = (count==DEPTH), taken from registered state.
  - Enqueue is blocked while full, even if a dequeue occurs in the same cycle.
  - I_Valid while full: input ignored, O_Overflow set (sticky until reset; not cleared by flush).
- Simultaneous enqueue and dequeue when non-full and non-empty: count unchanged; both pointers advance.
- Pointer wrap-around: modulo DEPTH; count distinguishes full from empty.
- Bypass register, updated on each enqueue:
  - O_WB_DstIdx/O_WB_Data <= I_DstIdx/I_Data; O_WB_Valid <= 1.
  - When not valid, O_WB_DstIdx='1, so the reserved index never matches a source index.
- Bypass clear: O_WB_Valid -> 0 (index -> '1, data -> 0) in the cycle after the dequeue of the entry that was last accepted, i.e. dequeue with count==1 and no enqueue in the same cycle.
  - If an enqueue coincides with that dequeue, the bypass takes the new entry and stays valid.
- I_Flush:
  - Next cycle: FIFO empty, count 0, bypass invalid.
  - Flush has priority over same-cycle enqueue and dequeue; O_RF_We is forced 0 during the flush cycle.
- I_DstIdx == '1 on input is illegal; the behaviour is undefined and verification asserts it never happens.

Test Plan:
- Reset, then single write: I_Valid with Idx=5, Data=0x11 in cycle 0, I_RF_Ready=1.
  - Cycle 1: O_RF_We=1, Idx=5, Data=0x11; O_WB_Valid=1, O_WB_DstIdx=5.
  - Cycle 2: O_WB_Valid=0, O_WB_DstIdx=0xFF, O_Count=0.
- Fill: I_RF_Ready=0, 4 writes with Idx 1..4.
  - O_Count=4, O_Stall=1.
  - 5th I_Valid (Idx 9) is ignored and O_Overflow=1.
  - Raising I_RF_Ready then drains Idx 1,2,3,4 in order over 4 cycles.
- Simultaneous enqueue/dequeue: count=2 with I_Valid and I_RF_Ready held for 6 cycles.
  - O_Count stays 2; the output order matches the input order across pointer wrap.
  - The bypass tracks the newest index every cycle.
- Full with dequeue: count=4 with I_Valid and I_RF_Ready in the same cycle.
  - Input ignored, O_Overflow=1, next O_Count=3.
- Flush: count=3, bypass valid; assert I_Flush together with I_Valid.
  - O_RF_We=0 during the flush cycle.
  - Next cycle: count=0, O_WB_Valid=0, O_Overflow unchanged.
- Async reset asserted mid-drain (count=2) between clock edges.
  - All outputs take reset values immediately, with no clock edge needed.
